// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses framed, checksummed blocks into the instruction and
// data memories of the core, then releases the core on a GO command.
module boot_loader #(
    parameter int INST_DEPTH = 32,
    parameter int DATA_DEPTH = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_run,
    output logic              err,
    output logic [7:0]        frame_cnt
);

    // Handshake: a byte transfers on any posedge where in_valid && in_ready.
    // in_ready is registered and stays high in every state except RUN.

    localparam logic [7:0] CMD_INST = 8'hA1;
    localparam logic [7:0] CMD_DATA = 8'hA2;
    localparam logic [7:0] CMD_GO   = 8'hF0;

    localparam logic [ADDR_W-1:0] INST_MASK = ADDR_W'(INST_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DATA_MASK = ADDR_W'(DATA_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_RUN  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              target_inst;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_mask;
    logic [7:0]        remaining;
    logic [7:0]        sum;
    logic [7:0]        sum_next;
    logic              set_err;
    logic              frame_ok;
    logic              write_byte;

    assign accept   = in_valid && in_ready;
    assign sum_next = sum + in_data;
    assign ptr_mask = target_inst ? INST_MASK : DATA_MASK;

    always_comb begin
        state_next = state;
        set_err    = 1'b0;
        frame_ok   = 1'b0;
        write_byte = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_data == CMD_INST || in_data == CMD_DATA) begin
                        state_next = S_ADDR;
                    end else if (in_data == CMD_GO) begin
                        // GO is silently dropped once an error has been seen.
                        if (!err) state_next = S_RUN;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (accept) state_next = S_LEN;
            end
            S_LEN: begin
                if (accept) state_next = (in_data != 8'd0) ? S_DATA : S_CSUM;
            end
            S_DATA: begin
                if (accept) begin
                    write_byte = 1'b1;
                    if (remaining == 8'd1) state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (sum_next == 8'd0) frame_ok = 1'b1;
                    else                  set_err  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                state_next = S_RUN;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            core_run    <= 1'b0;
            imem_we     <= 1'b0;
            dmem_we     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'd0;
            err         <= 1'b0;
            frame_cnt   <= 8'd0;
            target_inst <= 1'b0;
            ptr         <= '0;
            remaining   <= 8'd0;
            sum         <= 8'd0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != S_RUN);
            core_run <= (state_next == S_RUN);
            imem_we  <= 1'b0;
            dmem_we  <= 1'b0;

            if (accept) begin
                // The CMD byte is excluded from the checksum; everything after it is summed.
                sum <= (state == S_IDLE) ? 8'd0 : sum_next;
                case (state)
                    S_IDLE: target_inst <= (in_data == CMD_INST);
                    S_ADDR: ptr         <= ADDR_W'(in_data) & ptr_mask;
                    S_LEN:  remaining   <= in_data;
                    default: ;
                endcase
            end

            if (write_byte) begin
                imem_we   <= target_inst;
                dmem_we   <= !target_inst;
                mem_addr  <= ptr;
                mem_wdata <= in_data;
                ptr       <= (ptr + 1'b1) & ptr_mask;
                remaining <= remaining - 8'd1;
            end

            if (set_err) err <= 1'b1;
            if (frame_ok && frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: drives framed byte streams and checks memory writes through a
// timestamped expected queue, plus frame_cnt/err/core_run/in_ready against a frame-level model.
module tb_boot_loader;

    localparam int INST_DEPTH = 32;
    localparam int DATA_DEPTH = 64;
    localparam int ADDR_W     = 6;
    localparam int EW         = 1 + ADDR_W + 8 + 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_run;
    logic              err;
    logic [7:0]        frame_cnt;

    boot_loader #(.INST_DEPTH(INST_DEPTH), .DATA_DEPTH(DATA_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .dmem_we(dmem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_run(core_run), .err(err), .frame_cnt(frame_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    // entry = {is_inst, addr, data, posedge index of the accepting edge}
    logic [EW-1:0] exp_q[$];
    logic [7:0]    pl[$];

    bit err_m;
    int frame_m;
    bit run_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the head of the queue, in the cycle after acceptance.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (imem_we === 1'b1 || dmem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'({imem_we, dmem_we, mem_addr, mem_wdata}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_strobes", 32'({imem_we, dmem_we}), 32'({e[EW-1], !e[EW-1]}));
                check("wr_addr", 32'(mem_addr), 32'(e[EW-2 -: ADDR_W]));
                check("wr_data", 32'(mem_wdata), 32'(e[39:32]));
                check("wr_cycle", 32'(pcnt), e[31:0]);
            end
        end else if (exp_q.size() > 0 && int'(exp_q[0][31:0]) < pcnt) begin
            e = exp_q.pop_front();
            check("missing_write_at", 32'(pcnt), e[31:0]);
        end
    end

    // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        check("in_ready_before_byte", 32'(in_ready), 32'(!run_m));
        @(negedge clk);
    endtask

    task automatic gap(input bit gaps);
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
    endtask

    // Sends one block frame using payload pl; stop_after >= 0 truncates after that many payload bytes.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input bit bad,
                              input bit gaps, input int stop_after);
        bit         inst;
        int         depth;
        logic [7:0] s;
        logic [7:0] cs;
        inst  = (cmd == 8'hA1);
        depth = inst ? INST_DEPTH : DATA_DEPTH;
        send_byte(cmd);
        gap(gaps);
        send_byte(addr);
        gap(gaps);
        send_byte(8'(pl.size()));
        s = addr + 8'(pl.size());
        for (int i = 0; i < pl.size(); i++) begin
            if (i == stop_after) return;
            gap(gaps);
            exp_q.push_back({inst, ADDR_W'((int'(addr) + i) % depth), pl[i], 32'(pcnt + 1)});
            send_byte(pl[i]);
            s = s + pl[i];
        end
        cs = 8'd0 - s;
        if (bad) cs = cs + 8'($urandom_range(1, 255));
        gap(gaps);
        send_byte(cs);
        if (bad) err_m = 1'b1;
        else if (frame_m < 255) frame_m++;
    endtask

    task automatic send_go();
        send_byte(8'hF0);
        if (!err_m) run_m = 1'b1;
    endtask

    task automatic send_unknown(input logic [7:0] b);
        send_byte(b);
        err_m = 1'b1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(frame_m));
        check({tag, "_err"}, 32'(err), 32'(err_m));
        check({tag, "_core_run"}, 32'(core_run), 32'(run_m));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(!run_m));
    endtask

    task automatic do_reset(input int ncyc);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (ncyc) @(negedge clk);
        check("reset_outputs", 32'({in_ready, imem_we, dmem_we, mem_addr, mem_wdata, core_run, err, frame_cnt}), 32'd0);
        rst = 1'b0;
        err_m = 1'b0; frame_m = 0; run_m = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_core_run", 32'(core_run), 32'd0);
        check("post_reset_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic random_session(input int nframes);
        logic [7:0] cmd;
        logic [7:0] u;
        int         len;
        do_reset(2);
        for (int f = 0; f < nframes; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                do u = 8'($urandom); while (u == 8'hA1 || u == 8'hA2 || u == 8'hF0);
                send_unknown(u);
            end else begin
                cmd = ($urandom_range(0, 1) == 1) ? 8'hA1 : 8'hA2;
                len = $urandom_range(0, 8);
                pl.delete();
                for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
                send_frame(cmd, 8'($urandom), ($urandom_range(0, 7) == 0), 1'b1, -1);
            end
            gap(1'b1);
        end
        check_status("rand_frames");
        send_go();
        in_valid = 1'b0;
        @(negedge clk);
        check_status("rand_go");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        do_reset(2);

        // Instruction block then GO, back-to-back.
        pl = '{8'h20, 8'h08, 8'h00, 8'h05};
        send_frame(8'hA1, 8'h00, 1'b0, 1'b0, -1);
        check_status("inst_frame");
        send_go();
        in_valid = 1'b0;
        check_status("go_accepted");
        @(negedge clk);
        check_status("run_holds");

        // Data block wrapping past the top of data memory.
        do_reset(2);
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(8'hA2, 8'h3E, 1'b0, 1'b0, -1);
        check_status("data_wrap");

        // Instruction block wrapping at depth 32 with high ADDR bits ignored.
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(8'hA1, 8'hFE, 1'b0, 1'b0, -1);
        check_status("inst_wrap");

        // Bad checksum: write stays, err set, GO refused.
        do_reset(2);
        pl = '{8'hFF};
        send_frame(8'hA1, 8'h00, 1'b1, 1'b0, -1);
        check_status("bad_csum");
        send_go();
        in_valid = 1'b0;
        @(negedge clk);
        check_status("go_refused");

        // Unknown command, then LEN=0 frame.
        do_reset(2);
        send_unknown(8'h55);
        check_status("unknown_cmd");
        pl.delete();
        send_frame(8'hA1, 8'h10, 1'b0, 1'b0, -1);
        check_status("len0_frame");

        // Reset mid-frame, then a fresh frame.
        do_reset(2);
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(8'hA2, 8'h05, 1'b0, 1'b0, 2);
        do_reset(2);
        pl = '{8'h9A, 8'hBC};
        send_frame(8'hA1, 8'h07, 1'b0, 1'b0, -1);
        check_status("after_mid_reset");

        // frame_cnt saturation.
        do_reset(2);
        pl.delete();
        for (int f = 0; f < 258; f++) send_frame(8'hA2, 8'($urandom), 1'b0, 1'b0, -1);
        check_status("saturate");

        // Randomized sessions with gaps in in_valid.
        random_session(30);
        random_session(40);

        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
